// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Consumers: uart_tx_scheduler_if, rr_arbiter, uart_tx_scheduler.
package uart_tx_sched_pkg;

  localparam int DATA_W      = 8;
  localparam int DEF_NUM_REQ = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester/transmitter bundle for uart_tx_scheduler.
// The master side holds the requesters and the transmitter; the slave side is the scheduler.
interface uart_tx_scheduler_if
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        sent;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;

  modport master (
    output req, req_data, tx_done,
    input  ack, sent, tx_start, tx_data, busy, grant_id
  );

  modport slave (
    input  req, req_data, tx_done,
    output ack, sent, tx_start, tx_data, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_scheduler_arbiter.sv
// Combinational arbiter: first requester found scanning upward from ptr, wrapping.
// With UART_TX_SCHED_FIXED_PRIO_EN defined the scan always starts at index 0.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] start;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  assign start      = '0;
`else
  assign start = ptr;
`endif

  always_comb begin
    int               j;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    j         = 0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap keeps non-power-of-two NUM_REQ correct.
      j = int'(start) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among NUM_REQ byte requesters (IDLE -> SEND -> RELEASE).
// Round-robin by default; define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index priority.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = uart_tx_sched_pkg::DATA_W
) (
  input logic                clk,
  input logic                rst,
  uart_tx_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] sent_q, sent_d;
  logic               tx_start_q, tx_start_d;
  logic [DATA_W-1:0]  tx_data_q, tx_data_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic               busy_q;

  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic [IDX_W-1:0]   ptr_q;
  logic [DATA_W-1:0]  win_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .grant     (gnt_oh),
    .grant_idx (gnt_idx),
    .valid     (gnt_vld)
  );

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  logic [IDX_W-1:0] ptr_d;

  // Pointer moves only when a grant is actually issued, never on idle cycles.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && gnt_vld)
      ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt_oh[k]) win_byte = bus.req_data[k*DATA_W +: DATA_W];
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    sent_d     = '0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    gid_d      = gid_q;
    unique case (state_q)
      S_IDLE: begin
        // tx_done is deliberately not looked at here.
        if (gnt_vld) begin
          ack_d      = gnt_oh;
          tx_data_d  = win_byte;
          gid_d      = gnt_idx;
          tx_start_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        tx_start_d = 1'b1;
        if (bus.tx_done) begin
          sent_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gid_q;
          tx_start_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // One low cycle lets the transmitter clear its done flag.
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ack_q      <= '0;
      sent_q     <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      gid_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      sent_q     <= sent_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      gid_q      <= gid_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign bus.ack      = ack_q;
  assign bus.sent     = sent_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one transmitter (legal 2..8).
REQ-002 Parameter DATA_W, default 8, byte width, fixed at 8 to match transmitter data input.
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  NUM_REQ  per-requester "byte pending"; held until ack.
REQ-006 Port req_data  input  NUM_REQ*DATA_W  flattened bytes; requester k at bits [k*8+7:k*8].
REQ-007 Port ack  output  NUM_REQ  one-hot, one-cycle pulse; byte latched.
REQ-008 Port sent  output  NUM_REQ  one-hot, one-cycle pulse; granted byte's frame completed.
REQ-009 Port tx_start  output  1  level start to transmitter; held for the whole frame.
REQ-010 Port tx_data  output  8  byte to transmitter; stable while tx_start high.
REQ-011 Port tx_done  input  1  transmitter frame-complete flag; stays high until tx_start drops.
REQ-012 Port busy  output  1  high in any state except IDLE.
REQ-013 Port grant_id  output  clog2(NUM_REQ)  index of the requester currently being served.

Function
REQ-014 FSM states: IDLE, SEND, RELEASE; all outputs registered.
REQ-015 IDLE with any req bit high: arbitrate, latch the winner's byte into tx_data, pulse its ack, set grant_id, raise tx_start, enter SEND; all within one edge.
REQ-016 Latency: req sampled high at edge N gives ack and tx_start high during cycle N..N+1.
REQ-017 SEND: hold tx_start=1 and tx_data constant; on tx_done=1 pulse sent[grant_id], drop tx_start, enter RELEASE.
REQ-018 RELEASE: hold tx_start=0 for exactly one cycle so the transmitter clears done; then IDLE.
REQ-019 Back-to-back minimum: new frame start 2 cycles after tx_done observed.
REQ-020 Round-robin default: after serving k, priority order k+1, k+2, ..., wrapping modulo NUM_REQ, k last.
REQ-021 Round-robin pointer advances only on grant; it never advances on idle cycles.
REQ-022 req bits rising during SEND/RELEASE are held pending; they are not acked until IDLE.
REQ-023 req dropped before ack: no grant, no ack, nothing sent.
REQ-024 tx_done high while in IDLE or RELEASE: ignored; no sent pulse.
REQ-025 At most one ack bit and one sent bit high in any cycle.

Reset
REQ-026 rst asserted: tx_start=0, tx_data=0, ack=0, sent=0, busy=0, grant_id=0, state IDLE, RR pointer priority to index 0; effect immediate, without waiting for clk.
REQ-027 Reset mid-frame drops tx_start asynchronously, aborting the transmitter frame; the in-flight byte gets no sent pulse and is lost.
REQ-028 First edge after rst deassertion behaves as IDLE.

Configuration
REQ-029 Macro UART_TX_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins; RR pointer logic removed.
REQ-030 Macro undefined: round-robin per REQ-020.

Structure
REQ-031 Package uart_tx_sched_pkg holds the FSM state enum, the DATA_W=8 constant and the default NUM_REQ.
REQ-032 Arbitration is a sub-module rr_arbiter (req vector plus pointer in; one-hot grant and index out; combinational).
REQ-033 rr_arbiter under UART_TX_SCHED_FIXED_PRIO_EN: it ignores the pointer.

Verification
REQ-034 Single request: req[2]=1 with byte 0xA5 -> ack[2] one pulse, tx_data=0xA5, tx_start high until tx_done, then sent[2] pulse, 1 cycle tx_start low.
REQ-035 All four requesting continuously: grant order 0,1,2,3,0 with RR; with macro defined, 0,0,0.
REQ-036 Wrap: last served 3, req=0b1001 -> grant 0 next, then 3.
REQ-037 Request raised during SEND: req[1] rises mid-frame -> ack[1] exactly 1 cycle after RELEASE, not earlier.
REQ-038 Reset mid-frame: rst pulse while in SEND -> tx_start 0 before the next clk, no sent pulse, busy=0, next grant starts from index 0.
REQ-039 Spurious tx_done=1 in IDLE with req=0 -> no sent, state stays IDLE.
